// File: rtl/btn_event_arbiter_if.sv
// Event channel between btn_event_arbiter and its consumer.
// Handshake: the master raises evt_valid with evt_id; both stay stable until
// a rising edge samples evt_valid & evt_ready, at which point the event is
// transferred. The consumer may drive evt_ready freely (it may depend on
// evt_valid); the producer never withdraws an offered event.
interface btn_event_arbiter_if #(
  parameter int ID_W = 2
) ();
  logic            evt_valid;
  logic [ID_W-1:0] evt_id;
  logic            evt_ready;

  modport master (output evt_valid, output evt_id, input evt_ready);
  modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter: debounces N_BTN push-buttons with release-triggered
// settle counters, latches each debounced release as a pending event and
// serialises pending events round-robin onto one valid/ready channel.
// Optional macro BTN_ARB_SYNC_EN adds a 2-flop synchroniser on btn
// (adds exactly 2 cycles to every release-to-event latency).
module btn_event_arbiter #(
  parameter int N_BTN  = 4,
  parameter int CNT_W  = 8,
  parameter int SETTLE = 255,
  parameter int ID_W   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_BTN-1:0]    btn,
  btn_event_arbiter_if.master evt,
  output logic [N_BTN-1:0]    ovf,
  input  logic                ovf_clr
);

  logic [N_BTN-1:0] btn_s;
  logic [N_BTN-1:0] rel;
  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] grant_vec;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  rr_ptr;
  logic             found;
  logic             slot_free;

`ifdef BTN_ARB_SYNC_EN
  logic [N_BTN-1:0] sync_q1;
  logic [N_BTN-1:0] sync_q2;

  // Two-flop synchroniser for asynchronous board inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
    end
  end

  assign btn_s = sync_q2;
`else
  assign btn_s = btn;
`endif

  // One settle counter per button; the release pulse fires when it reaches 1.
  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    logic [CNT_W-1:0] cnt;

    // Reload while held, count down after release, park at zero.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt <= '0;
      end else if (btn_s[g]) begin
        cnt <= CNT_W'(SETTLE);
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end

    assign rel[g] = ~btn_s[g] & (cnt == CNT_W'(1));
  end

  // The slot can take a new event when empty or when it is being consumed now.
  assign slot_free = ~evt.evt_valid | evt.evt_ready;

  // Round-robin search starting just after the last granted button.
  always_comb begin
    int idx;
    idx       = 0;
    found     = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_BTN) idx = idx - N_BTN;
      if (!found && ((pending & (N_BTN'(1) << idx)) != '0)) begin
        found     = 1'b1;
        grant_idx = ID_W'(idx);
        if (slot_free) grant_vec = N_BTN'(1) << idx;
      end
    end
  end

  // Pending events and sticky overflow flags; a new release beats a grant
  // and a new overflow beats ovf_clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
      ovf     <= '0;
    end else begin
      pending <= (pending & ~grant_vec) | rel;
      ovf     <= (ovf_clr ? '0 : ovf) | (rel & pending & ~grant_vec);
    end
  end

  // Output slot and round-robin pointer; slot holds while backpressured.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evt.evt_valid <= 1'b0;
      evt.evt_id    <= '0;
      rr_ptr        <= ID_W'(N_BTN - 1);
    end else if (slot_free) begin
      if (found) begin
        evt.evt_valid <= 1'b1;
        evt.evt_id    <= grant_idx;
        rr_ptr        <= grant_idx;
      end else begin
        evt.evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter with SETTLE=8, four buttons.
module tb_btn_event_arbiter;

`ifdef BTN_ARB_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  // Ticks from driving the release to seeing evt_valid with a free slot.
  localparam int LAT = 9 + SYNC_LAT;

  logic       clk;
  logic       rst;
  logic [3:0] btn;
  logic [3:0] ovf;
  logic       ovf_clr;
  int         total;
  int         bad;

  btn_event_arbiter_if #(.ID_W(2)) evt_if ();

  btn_event_arbiter #(
    .N_BTN (4),
    .CNT_W (8),
    .SETTLE(8),
    .ID_W  (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn    (btn),
    .evt    (evt_if),
    .ovf    (ovf),
    .ovf_clr(ovf_clr)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n cycles, landing 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Press the buttons in mask for n cycles, then release them.
  task automatic press(input logic [3:0] mask, input int n);
    btn = mask;
    tick(n);
    btn = 4'b0000;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    btn   = 4'b0000;
    ovf_clr = 1'b0;
    evt_if.evt_ready = 1'b0;
    tick(2);
    chk("rst_valid", 32'(evt_if.evt_valid), 32'd0);
    chk("rst_id", 32'(evt_if.evt_id), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b1;
    tick(1);

    // Single press/release with ready held high.
    evt_if.evt_ready = 1'b1;
    press(4'b0001, 5);
    chk("t1_no_early", 32'(evt_if.evt_valid), 32'd0);
    tick(LAT - 1);
    chk("t1_not_yet", 32'(evt_if.evt_valid), 32'd0);
    tick(1);
    chk("t1_valid", 32'(evt_if.evt_valid), 32'd1);
    chk("t1_id", 32'(evt_if.evt_id), 32'd0);
    tick(1);
    chk("t1_drop", 32'(evt_if.evt_valid), 32'd0);
    tick(3);
    chk("t1_no_second", 32'(evt_if.evt_valid), 32'd0);

    // Bounce: 1,0,1,0 at 3-cycle spacing, one event from the final release.
    press(4'b0001, 3);
    tick(3);
    press(4'b0001, 3);
    chk("t2_bounce_quiet", 32'(evt_if.evt_valid), 32'd0);
    tick(LAT - 1);
    chk("t2_not_yet", 32'(evt_if.evt_valid), 32'd0);
    tick(1);
    chk("t2_valid", 32'(evt_if.evt_valid), 32'd1);
    chk("t2_id", 32'(evt_if.evt_id), 32'd0);
    tick(1);
    chk("t2_drop", 32'(evt_if.evt_valid), 32'd0);
    tick(4);
    chk("t2_single", 32'(evt_if.evt_valid), 32'd0);

    // Fresh pointer so button 0 has first priority.
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);

    // Simultaneous releases of all four buttons.
    press(4'b1111, 3);
    tick(LAT);
    for (int i = 0; i < 4; i++) begin
      chk("t3_valid", 32'(evt_if.evt_valid), 32'd1);
      chk("t3_order", 32'(evt_if.evt_id), 32'(i));
      tick(1);
    end
    chk("t3_empty", 32'(evt_if.evt_valid), 32'd0);

    // Buttons 1 and 3 together after pointer sits at 3.
    press(4'b1010, 3);
    tick(LAT);
    chk("t3b_first", 32'(evt_if.evt_id), 32'd1);
    chk("t3b_v1", 32'(evt_if.evt_valid), 32'd1);
    tick(1);
    chk("t3b_second", 32'(evt_if.evt_id), 32'd3);
    chk("t3b_v2", 32'(evt_if.evt_valid), 32'd1);
    tick(1);
    chk("t3b_empty", 32'(evt_if.evt_valid), 32'd0);

    // Backpressure: id 2 held for 10 cycles, btn0 queued behind it.
    evt_if.evt_ready = 1'b0;
    btn = 4'b0101;
    tick(3);
    btn = 4'b0001;
    tick(2);
    btn = 4'b0000;
    tick(LAT - 2);
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_valid", 32'(evt_if.evt_valid), 32'd1);
      chk("t4_hold_id", 32'(evt_if.evt_id), 32'd2);
      if (i < 9) tick(1);
    end
    evt_if.evt_ready = 1'b1;
    tick(1);
    chk("t4_next_valid", 32'(evt_if.evt_valid), 32'd1);
    chk("t4_next_id", 32'(evt_if.evt_id), 32'd0);
    tick(1);
    chk("t4_empty", 32'(evt_if.evt_valid), 32'd0);

    // Overflow: slot busy with id 2, btn1 released twice.
    evt_if.evt_ready = 1'b0;
    press(4'b0100, 3);
    tick(LAT);
    chk("t5_slot_id", 32'(evt_if.evt_id), 32'd2);
    press(4'b0010, 3);
    tick(LAT);
    chk("t5_ovf_none", 32'(ovf), 32'd0);
    press(4'b0010, 3);
    tick(LAT);
    chk("t5_ovf_set", 32'(ovf), 32'b0010);
    chk("t5_still_id2", 32'(evt_if.evt_id), 32'd2);
    evt_if.evt_ready = 1'b1;
    tick(1);
    chk("t5_deliver_v", 32'(evt_if.evt_valid), 32'd1);
    chk("t5_deliver_id", 32'(evt_if.evt_id), 32'd1);
    tick(1);
    chk("t5_one_only", 32'(evt_if.evt_valid), 32'd0);
    chk("t5_ovf_sticky", 32'(ovf), 32'b0010);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("t5_ovf_clr", 32'(ovf), 32'd0);

    // Asynchronous reset with an event in the slot, overflow set, count running.
    evt_if.evt_ready = 1'b0;
    press(4'b0001, 3);
    tick(LAT);
    chk("t6_slot_v", 32'(evt_if.evt_valid), 32'd1);
    chk("t6_slot_id", 32'(evt_if.evt_id), 32'd0);
    press(4'b0010, 3);
    tick(LAT);
    press(4'b0010, 3);
    tick(LAT);
    chk("t6_ovf_pre", 32'(ovf), 32'b0010);
    press(4'b0100, 3);
    tick(3);
    #3;
    rst = 1'b0;
    #1;
    chk("t6_async_valid", 32'(evt_if.evt_valid), 32'd0);
    chk("t6_async_id", 32'(evt_if.evt_id), 32'd0);
    chk("t6_async_ovf", 32'(ovf), 32'd0);
    tick(2);
    rst = 1'b1;
    evt_if.evt_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("t6_no_stale", 32'(evt_if.evt_valid), 32'd0);
    end
    press(4'b0001, 3);
    tick(LAT);
    chk("t6_after_v", 32'(evt_if.evt_valid), 32'd1);
    chk("t6_after_id", 32'(evt_if.evt_id), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_event_arbiter.md
Name: btn_event_arbiter

Overview:
- Debounces N_BTN raw push-buttons with one counter per button (release-triggered settle counter).
- Latches each debounced release as a pending event.
- Round-robin arbiter serialises pending events to a single consumer over a valid/ready handshake.
- Sits between board buttons and the UI/control FSM so that several buttons share one event channel.

Parameters:
- N_BTN, 4, number of buttons; legal range 2..8.
- CNT_W, 8, settle counter width.
- SETTLE, 255, counter load value while a button is held; legal range 2..2^CNT_W-1.
- ID_W, 2, width of evt_id; must satisfy 2^ID_W >= N_BTN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- btn  in  N_BTN  raw button levels, 1 = pressed.
- evt_valid  out  1  event available.
- evt_id  out  ID_W  index of the button whose release is reported.
- evt_ready  in  1  consumer accepts the event when evt_valid & evt_ready at a rising edge.
- ovf  out  N_BTN  sticky per-button flag: an event was dropped.
- ovf_clr  in  1  synchronous clear of all ovf bits.

Behaviour:
- Reset (rst=0, asynchronous): all counters 0, pending 0, evt_valid 0, evt_id 0, ovf 0, rr_ptr = N_BTN-1 (button 0 has first priority). A mid-operation reset discards all pending and in-flight events.
- Per-button counter cnt_i, updated every edge:
  - btn_i=1: load SETTLE.
  - btn_i=0 and cnt_i!=0: decrement.
  - otherwise: hold.
- Release pulse rel_i = ~btn_i & (cnt_i==1), combinational. It fires exactly once, SETTLE-1 edges after the first edge that samples btn_i=0 following a press. A re-press before the count reaches 1 reloads the counter and no pulse is produced.
- pending_i update at each edge:
  - set by rel_i;
  - cleared when granted;
  - if rel_i and grant_i occur in the same cycle, pending_i stays 1 (the new event is kept).
- Overflow: rel_i while pending_i=1 and not granted that cycle leaves pending_i=1 and sets ovf_i. ovf_i is sticky and is cleared only by ovf_clr. If ovf_clr and a new overflow coincide, the overflow wins (bit reads 1).
- Output slot: one register holding evt_valid and evt_id.
  - The slot is free when evt_valid=0, or when evt_valid & evt_ready in the current cycle.
  - When the slot is free and any pending bit is set, grant one button:
    - search order rr_ptr+1, rr_ptr+2, … modulo N_BTN;
    - the first set bit wins;
    - at the edge: evt_valid<=1, evt_id<=grant index, rr_ptr<=grant index, pending[grant] cleared.
  - When the slot is free and nothing is pending: evt_valid<=0 at the edge.
  - While evt_valid=1 and evt_ready=0: evt_id and evt_valid hold stable.
- Latency: rel_i at edge k sets pending at edge k. With the slot free, evt_valid=1 after edge k+1 (one cycle from pending to valid). Back-to-back accepts sustain one event per cycle.
- Arbitration is purely combinational on registered pending and rr_ptr. There is no starvation: a pending button waits at most N_BTN-1 grants.

Optional Feature:
- Macro: BTN_ARB_SYNC_EN.
- Defined: btn passes through a 2-flop synchroniser per bit (reset value 0) before the counters. Every release-to-event latency increases by exactly 2 cycles.
- Undefined: btn drives the counters directly. Inputs are assumed synchronous to clk.

Test Plan:
- Reset, SETTLE=8: hold btn=4'b0001 for 5 cycles, then release. rel_0 fires 7 edges after the first low sample; evt_valid=1, evt_id=0 one cycle later. Hold evt_ready=1: evt_valid drops next cycle with no second event.
- Bounce: btn0 toggles 1,0,1,0 at 3-cycle spacing, then stays 0. Exactly one event, id 0, timed from the final release.
- Simultaneous releases of btn0..btn3, evt_ready=1 held: ids in order 0,1,2,3 on consecutive cycles. Then release btn1 and btn3 together: order 1 (after ptr=3), then 3.
- Backpressure: event id 2 presented with evt_ready=0 for 10 cycles. evt_id stays 2, evt_valid stays 1. A btn0 release meanwhile is pending and is delivered the cycle after acceptance.
- Overflow: evt_ready=0, release btn1 twice. ovf=4'b0010, only one id-1 event delivered. Pulse ovf_clr: ovf=0.
- Assert rst=0 asynchronously mid-count and while evt_valid=1: evt_valid=0, ovf=0 immediately. After rst=1, no stale event appears.
